// File: rtl/ct_mod_chain.sv
// Cascade of NUM_STAGES run-time modulo-N counters (stage 0 least significant)
// with up/down counting, synchronous clear/load and per-stage terminal flags.
module ct_mod_chain #(
    parameter int NUM_STAGES = 3,
    parameter int W          = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    up,
    input  logic                    clr,
    input  logic                    ld,
    input  logic [NUM_STAGES*W-1:0] ld_val,
    input  logic [NUM_STAGES*W-1:0] N,
    output logic [NUM_STAGES*W-1:0] ct_out,
    output logic [NUM_STAGES-1:0]   z,
    output logic                    tc
);

    logic [NUM_STAGES*W-1:0] ct_q;
    logic [NUM_STAGES*W-1:0] ct_d;
    logic [NUM_STAGES-1:0]   step;

    // N-1 widened by one bit so N=0 cannot wrap to a small value
    function automatic logic [W:0] n_minus_1(input logic [W-1:0] n);
        return {1'b0, n} - {{W{1'b0}}, 1'b1};
    endfunction

    function automatic logic is_degenerate(input logic [W-1:0] n);
        return (n <= W'(1));
    endfunction

    function automatic logic term_flag(input logic [W-1:0] ct,
                                       input logic [W-1:0] n,
                                       input logic         dir_up);
        logic [W:0] nm1;
        nm1 = n_minus_1(n);
        if (is_degenerate(n))
            return 1'b1;
        else if (dir_up)
            return ({1'b0, ct} == nm1);
        else
            return (ct == '0);
    endfunction

    // Compare-and-wrap; out-of-range counts fall onto the wrap target
    function automatic logic [W-1:0] step_val(input logic [W-1:0] ct,
                                              input logic [W-1:0] n,
                                              input logic         dir_up);
        logic [W:0] nm1;
        nm1 = n_minus_1(n);
        if (is_degenerate(n))
            return '0;
        else if (dir_up)
            return ({1'b0, ct} >= nm1) ? '0 : ct + W'(1);
        else
            return ((ct == '0) || (ct >= n)) ? nm1[W-1:0] : ct - W'(1);
    endfunction

    function automatic logic [W-1:0] load_val(input logic [W-1:0] v,
                                              input logic [W-1:0] n);
        return (v >= n) ? '0 : v;
    endfunction

    always_comb begin
        z = '0;
        for (int i = 0; i < NUM_STAGES; i++)
            z[i] = term_flag(ct_q[i*W +: W], N[i*W +: W], up);
    end

    // Carry ripple: a stage steps only when every lower stage is terminal
    always_comb begin
        logic carry;
        carry = en;
        step  = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            step[i] = carry;
            carry   = carry & z[i];
        end
    end

    always_comb begin
        ct_d = ct_q;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (clr)
                ct_d[i*W +: W] = '0;
            else if (ld)
                ct_d[i*W +: W] = load_val(ld_val[i*W +: W], N[i*W +: W]);
            else if (step[i])
                ct_d[i*W +: W] = step_val(ct_q[i*W +: W], N[i*W +: W], up);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ct_q <= '0;
        else
            ct_q <= ct_d;
    end

    assign ct_out = ct_q;
    assign tc     = en & (&z);

endmodule

// File: tb/tb_ct_mod_chain.sv
// Directed bench for ct_mod_chain: 3 stages of 7 bits, sec/min/hr style moduli.
module tb_ct_mod_chain;

    localparam int NS = 3;
    localparam int W  = 7;

    logic            clk = 1'b0;
    logic            rst;
    logic            en, up, clr, ld;
    logic [NS*W-1:0] ld_val, N;
    logic [NS*W-1:0] ct_out;
    logic [NS-1:0]   z;
    logic            tc;

    int n_checks = 0;
    int n_errors = 0;

    ct_mod_chain #(.NUM_STAGES(NS), .W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .up     (up),
        .clr    (clr),
        .ld     (ld),
        .ld_val (ld_val),
        .N      (N),
        .ct_out (ct_out),
        .z      (z),
        .tc     (tc)
    );

    always #5 clk = ~clk;

    function automatic logic [NS*W-1:0] pk(input int s2, input int s1, input int s0);
        return {W'(s2), W'(s1), W'(s0)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    int  tc_cnt;
    int  tc_cyc;
    logic [NS*W-1:0] held;

    initial begin
        rst = 1'b0; en = 1'b0; up = 1'b0; clr = 1'b0; ld = 1'b0;
        ld_val = '0; N = pk(24, 60, 60);
        @(negedge clk); #1;
        chk("rst_ct", 32'(ct_out), 32'(0));
        chk("rst_z_down", 32'(z), 32'(3'b111));
        chk("rst_tc_en0", 32'(tc), 32'(0));

        // 1: asynchronous reset mid-count
        @(negedge clk);
        rst = 1'b1;
        ld = 1'b1; ld_val = pk(0, 0, 42);
        tick();
        ld = 1'b0;
        #1 chk("ld_2a", 32'(ct_out), 32'(42));
        rst = 1'b0; up = 1'b1;
        #1;
        chk("async_rst", 32'(ct_out), 32'(0));
        chk("rst_z_up", 32'(z), 32'(3'b000));
        @(negedge clk);
        rst = 1'b1; en = 1'b1;
        tick();
        en = 1'b0;
        #1 chk("post_rst_step", 32'(ct_out), 32'(pk(0, 0, 1)));

        // 2: full cascade up count
        clr = 1'b1; tick(); clr = 1'b0;
        up = 1'b1; en = 1'b1;
        tc_cnt = 0; tc_cyc = -1;
        for (int c = 0; c < 86400; c++) begin
            if (tc) begin
                tc_cnt++;
                tc_cyc = c;
            end
            if (c == 86399)
                chk("pre_wrap_ct", 32'(ct_out), 32'(pk(23, 59, 59)));
            tick();
            if (c == 3599)
                chk("hour_ct", 32'(ct_out), 32'(pk(1, 0, 0)));
        end
        en = 1'b0;
        #1;
        chk("wrap_ct", 32'(ct_out), 32'(0));
        chk("tc_count", 32'(tc_cnt), 32'(1));
        chk("tc_cycle", 32'(tc_cyc), 32'(86399));

        // 3: down wrap from zero
        up = 1'b0; en = 1'b1;
        #1;
        chk("dn_z_pre", 32'(z), 32'(3'b111));
        chk("dn_tc_pre", 32'(tc), 32'(1));
        tick();
        en = 1'b0;
        #1;
        chk("dn_wrap_ct", 32'(ct_out), 32'(pk(23, 59, 59)));
        chk("dn_z_post", 32'(z), 32'(3'b000));

        // 4: priority and out-of-range load
        ld = 1'b1; en = 1'b1; ld_val = pk(5, 70, 10);
        tick();
        #1 chk("ld_oor", 32'(ct_out), 32'(pk(5, 0, 10)));
        clr = 1'b1;
        tick();
        clr = 1'b0; ld = 1'b0; en = 1'b0;
        #1 chk("clr_over_ld", 32'(ct_out), 32'(0));

        // 5: degenerate modulus and shrinking modulus
        N = pk(24, 60, 1); up = 1'b1; en = 1'b1;
        tick(); tick(); tick();
        en = 1'b0;
        #1;
        chk("n1_pass", 32'(ct_out), 32'(pk(0, 3, 0)));
        chk("n1_z0", 32'(z[0]), 32'(1));
        ld = 1'b1; ld_val = pk(0, 45, 0);
        tick();
        ld = 1'b0;
        N = pk(24, 10, 1); en = 1'b1;
        tick();
        en = 1'b0;
        #1 chk("shrink_up", 32'(ct_out), 32'(pk(0, 0, 0)));
        N = pk(24, 60, 1);
        ld = 1'b1;
        tick();
        ld = 1'b0;
        N = pk(24, 10, 1); up = 1'b0; en = 1'b1;
        tick();
        en = 1'b0;
        #1 chk("shrink_dn", 32'(ct_out), 32'(pk(0, 9, 0)));
        N = pk(1, 0, 1); en = 1'b1;
        #1;
        chk("all_deg_z", 32'(z), 32'(3'b111));
        chk("all_deg_tc", 32'(tc), 32'(1));
        en = 1'b0;
        #1 chk("all_deg_tc0", 32'(tc), 32'(0));

        // 6: hold and direction toggle
        @(negedge clk);
        N = pk(24, 60, 60); up = 1'b1;
        ld = 1'b1; ld_val = pk(3, 4, 59);
        tick();
        ld = 1'b0;
        #1;
        held = ct_out;
        chk("tog_z0_up", 32'(z[0]), 32'(1));
        for (int c = 0; c < 20; c++) tick();
        #1 chk("hold20", 32'(ct_out), 32'(pk(3, 4, 59)));
        chk("hold_eq", 32'(ct_out), 32'(held));
        up = 1'b0;
        #1 chk("tog_z0_dn", 32'(z[0]), 32'(0));
        en = 1'b1;
        tick();
        en = 1'b0;
        #1 chk("tog_step", 32'(ct_out), 32'(pk(3, 4, 58)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
